// File: rtl/gcd_requester.sv
// gcd_requester: queues operand pairs, issues them one at a time to a
// go/done GCD core with a done timeout, and returns each result over a
// valid/ready response port in request order.
module gcd_requester #(
   parameter int W       = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 31
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [W-1:0]               req_x,
   input  logic [W-1:0]               req_y,
   output logic                       core_go,
   output logic [W-1:0]               core_xin,
   output logic [W-1:0]               core_yin,
   input  logic                       core_done,
   input  logic [W-1:0]               core_gcd,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [W-1:0]               rsp_gcd,
   output logic                       rsp_err,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q,     state_d;
   logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
   logic [LW-1:0]   level_q,     level_d;
   logic            core_go_q,   core_go_d;
   logic [W-1:0]    core_xin_q,  core_xin_d;
   logic [W-1:0]    core_yin_q,  core_yin_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [W-1:0]    rsp_gcd_q,   rsp_gcd_d;
   logic            rsp_err_q,   rsp_err_d;
   logic [7:0]      cnt_q,       cnt_d;

   // Request storage; contents need no reset because the pointers and
   // level define which entries are live.
   logic [W-1:0]    mem_x [DEPTH];
   logic [W-1:0]    mem_y [DEPTH];

   logic            push;
   logic            pop;
   logic [W-1:0]    head_x;
   logic [W-1:0]    head_y;

   assign req_ready = (level_q < LW'(DEPTH));
   assign push      = req_valid && req_ready;
   // The FSM only takes a new entry when it is idle, so one core op is outstanding.
   assign pop       = (state_q == IDLE) && (level_q != '0);
   assign head_x    = mem_x[rd_ptr_q];
   assign head_y    = mem_y[rd_ptr_q];

   // Write accepted requests into the FIFO array.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_x[wr_ptr_q] <= req_x;
         mem_y[wr_ptr_q] <= req_y;
      end
   end

   // FIFO pointer and occupancy bookkeeping; pointers wrap at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
   end

   // Next-state and registered-output logic for the issue/wait/respond FSM.
   always_comb begin
      state_d     = state_q;
      core_go_d   = 1'b0;
      core_xin_d  = core_xin_q;
      core_yin_d  = core_yin_q;
      rsp_valid_d = rsp_valid_q;
      rsp_gcd_d   = rsp_gcd_q;
      rsp_err_d   = rsp_err_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               if ((head_x == '0) || (head_y == '0)) begin
                  // The core never terminates on a zero operand; answer locally.
                  rsp_gcd_d   = head_x | head_y;
                  rsp_err_d   = 1'b0;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  core_go_d  = 1'b1;
                  core_xin_d = head_x;
                  core_yin_d = head_y;
                  state_d    = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (core_done) begin
               rsp_gcd_d   = core_gcd;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (cnt_q == 8'(TIMEOUT)) begin
               rsp_gcd_d   = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         core_go_q   <= 1'b0;
         core_xin_q  <= '0;
         core_yin_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_gcd_q   <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         core_go_q   <= core_go_d;
         core_xin_q  <= core_xin_d;
         core_yin_q  <= core_yin_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_gcd_q   <= rsp_gcd_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign core_go   = core_go_q;
   assign core_xin  = core_xin_q;
   assign core_yin  = core_yin_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_gcd   = rsp_gcd_q;
   assign rsp_err   = rsp_err_q;
   assign level     = level_q;
   assign busy      = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: table of single requests plus hand-written
// sequences for back-to-back, timeout, back-pressure and mid-run reset.
module tb_gcd_requester;
   localparam int W     = 4;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_x;
   logic [W-1:0]  req_y;
   logic          core_go;
   logic [W-1:0]  core_xin;
   logic [W-1:0]  core_yin;
   logic          core_done;
   logic [W-1:0]  core_gcd;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_gcd;
   logic          rsp_err;
   logic          busy;
   logic [2:0]    level;

   always #5 clk = ~clk;

   gcd_requester #(.W(W), .DEPTH(DEPTH), .TIMEOUT(31)) dut (
      .clk(clk), .clr_n(clr_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
      .core_go(core_go), .core_xin(core_xin), .core_yin(core_yin),
      .core_done(core_done), .core_gcd(core_gcd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd), .rsp_err(rsp_err),
      .busy(busy), .level(level)
   );

   // Subtractive Euclid core model.
   logic [W-1:0] ma = '0, mb = '0, m_gcd = '0;
   logic         m_run = 1'b0, m_done = 1'b0;
   logic         core_en, inj_done;

   always @(posedge clk) begin
      if (core_go) begin
         ma <= core_xin; mb <= core_yin; m_run <= 1'b1; m_done <= 1'b0;
      end else if (m_run) begin
         if (ma == mb) begin m_done <= 1'b1; m_gcd <= ma; m_run <= 1'b0; end
         else if (ma > mb) ma <= ma - mb;
         else mb <= mb - ma;
      end else begin
         m_done <= 1'b0;
      end
   end
   assign core_done = (m_done & core_en) | inj_done;
   assign core_gcd  = m_gcd;

   // Monitor: collect responses, count go pulses, flag overlapping issues.
   int           cyc = 0, go_cnt = 0, viol = 0;
   bit           outstanding = 0;
   logic [W-1:0] last_go_x = '0, last_go_y = '0;
   logic [W-1:0] rq_gcd [$];
   logic         rq_err [$];

   always @(posedge clk) begin
      cyc++;
      if (!clr_n) begin
         outstanding = 0;
      end else begin
         if (core_go) begin
            go_cnt++;
            if (outstanding) viol++;
            outstanding = 1;
            last_go_x = core_xin;
            last_go_y = core_yin;
         end
         if (core_done) outstanding = 0;
         if (rsp_valid && rsp_ready) begin
            rq_gcd.push_back(rsp_gcd);
            rq_err.push_back(rsp_err);
            outstanding = 0;
            $display("rsp #%0d gcd=%0d err=%0d t=%0t", rq_gcd.size(), rsp_gcd, rsp_err, $time);
         end
      end
   end

   int checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Entered at a negedge; returns at the negedge after acceptance.
   task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
      int k = 0;
      req_valid = 1'b1; req_x = x; req_y = y;
      while (!req_ready && k < 300) begin @(negedge clk); k++; end
      if (!req_ready) chk("push_timeout", 0, 1);
      @(negedge clk);
      req_valid = 1'b0;
      $display("req x=%0d y=%0d t=%0t", x, y, $time);
   endtask

   task automatic wait_q(input int n, input string nm);
      int k = 0;
      while (rq_gcd.size() < n && k < 2000) begin @(negedge clk); k++; end
      chk(nm, (rq_gcd.size() >= n) ? 1 : 0, 1);
   endtask

   typedef struct {
      logic [W-1:0] x, y, g;
      logic         e;
      int           go;
   } vec_t;
   vec_t vt [9];

   initial begin
      int n, g0, t0, t1, k;
      logic [W-1:0] exp6 [6];
      clr_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0;
      rsp_ready = 1'b1; core_en = 1'b1; inj_done = 1'b0;

      vt[0] = '{4'd12, 4'd8,  4'd4, 1'b0, 1};
      vt[1] = '{4'd9,  4'd6,  4'd3, 1'b0, 1};
      vt[2] = '{4'd7,  4'd7,  4'd7, 1'b0, 1};
      vt[3] = '{4'd15, 4'd5,  4'd5, 1'b0, 1};
      vt[4] = '{4'd0,  4'd5,  4'd5, 1'b0, 0};
      vt[5] = '{4'd0,  4'd0,  4'd0, 1'b0, 0};
      vt[6] = '{4'd6,  4'd0,  4'd6, 1'b0, 0};
      vt[7] = '{4'd14, 4'd15, 4'd1, 1'b0, 1};
      vt[8] = '{4'd1,  4'd15, 4'd1, 1'b0, 1};

      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_core_go", core_go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 1);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);

      // Single requests from the table.
      for (int i = 0; i < 9; i++) begin
         n = rq_gcd.size(); g0 = go_cnt;
         push(vt[i].x, vt[i].y);
         wait_q(n + 1, "vec_rsp_arrived");
         chk($sformatf("vec%0d_gcd", i), rq_gcd[n], vt[i].g);
         chk($sformatf("vec%0d_err", i), rq_err[n], vt[i].e);
         chk($sformatf("vec%0d_go", i), go_cnt - g0, vt[i].go);
         if (vt[i].go != 0) begin
            chk($sformatf("vec%0d_xin", i), last_go_x, vt[i].x);
            chk($sformatf("vec%0d_yin", i), last_go_y, vt[i].y);
         end
         @(negedge clk);
         chk($sformatf("vec%0d_busy", i), busy, 0);
      end

      // Back-to-back requests served in order.
      n = rq_gcd.size(); g0 = go_cnt;
      push(4'd9, 4'd6); push(4'd7, 4'd7); push(4'd15, 4'd5);
      wait_q(n + 3, "b2b_rsp_arrived");
      chk("b2b_gcd0", rq_gcd[n], 3);
      chk("b2b_gcd1", rq_gcd[n+1], 7);
      chk("b2b_gcd2", rq_gcd[n+2], 5);
      chk("b2b_go", go_cnt - g0, 3);

      // Timeout: no done from the core.
      core_en = 1'b0;
      n = rq_gcd.size();
      push(4'd10, 4'd4);
      k = 0;
      while (!core_go && k < 50) begin @(negedge clk); k++; end
      t0 = cyc;
      k = 0;
      while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
      t1 = cyc;
      chk("to_latency", t1 - t0, 33);
      chk("to_gcd", rsp_gcd, 0);
      chk("to_err", rsp_err, 1);
      wait_q(n + 1, "to_rsp_arrived");
      @(negedge clk);
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("late_done_no_rsp", rq_gcd.size(), n + 1);
      chk("late_done_valid", rsp_valid, 0);
      chk("late_done_busy", busy, 0);
      core_en = 1'b1;

      // Back-pressure: fill the FIFO behind a parked response.
      exp6 = '{4'd4, 4'd3, 4'd7, 4'd5, 4'd4, 4'd1};
      rsp_ready = 1'b0;
      n = rq_gcd.size();
      push(4'd12, 4'd8); push(4'd9, 4'd6); push(4'd14, 4'd7);
      push(4'd15, 4'd10); push(4'd8, 4'd12);
      req_valid = 1'b1; req_x = 4'd5; req_y = 4'd3;
      repeat (20) @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_level", level, 4);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_no_rsp", rq_gcd.size(), n);
      rsp_ready = 1'b1;
      k = 0;
      while (!req_ready && k < 100) begin @(negedge clk); k++; end
      chk("bp_6th_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      wait_q(n + 6, "bp_rsp_arrived");
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("bp_gcd%0d", i), rq_gcd[n+i], exp6[i]);
         chk($sformatf("bp_err%0d", i), rq_err[n+i], 0);
      end

      // Reset during WAIT with two requests queued.
      core_en = 1'b0;
      n = rq_gcd.size();
      push(4'd10, 4'd4); push(4'd9, 4'd6); push(4'd7, 4'd7);
      repeat (5) @(negedge clk);
      chk("pre_rst_level", level, 2);
      clr_n = 1'b0;
      #1;
      chk("mid_rst_level", level, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_core_go", core_go, 0);
      chk("mid_rst_xin", core_xin, 0);
      chk("mid_rst_yin", core_yin, 0);
      chk("mid_rst_err", rsp_err, 0);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_no_rsp", rq_gcd.size(), n);
      core_en = 1'b1;
      push(4'd12, 4'd8);
      wait_q(n + 1, "post_rst_rsp_arrived");
      chk("post_rst_gcd", rq_gcd[n], 4);
      chk("post_rst_err", rq_err[n], 0);

      chk("go_overlap", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
